// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and defaults for the multi-port register file
//
// Purpose: clear-FSM state type and default geometry used by reg_file_mp
//          and reg_file_rd_port.
package reg_file_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - one registered read port of the register file
//
// Purpose: range-checks the read address, applies write-first and
//          clear-first bypass, and registers the result (1-cycle latency).
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   raddr_i         read address
//   mem_i           current storage contents
//   wr_en_i         a write is being accepted this cycle
//   waddr_i/wdata_i address/data of that write
//   clr_en_i        an entry is being zeroed this cycle
//   clr_addr_i      entry being zeroed
//   rdata_o         registered read data
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [WIDTH-1:0]  mem_i [DEPTH],
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             raddr_ok;

  assign raddr_ok = (32'(raddr_i) < 32'(DEPTH));

  // The storage update and this register load on the same edge, so the
  // in-flight write or clear is forwarded to make the read see the
  // post-edge contents.
  always_comb begin
    rdata_d = '0;
    if (raddr_ok) begin
      if (wr_en_i && (waddr_i == raddr_i)) begin
        rdata_d = wdata_i;
      end else if (clr_en_i && (clr_addr_i == raddr_i)) begin
        rdata_d = '0;
      end else begin
        rdata_d = mem_i[raddr_i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - flop-based register file, 1 write / 2 read ports, sequenced clear
//
// Purpose: DEPTH x WIDTH storage with one write port, two independent
//          registered read ports and a clear sequence that zeroes one entry
//          per cycle in ascending order.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   write_en/waddr/wdata  write port
//   raddr_a/rdata_a   read port A (1-cycle latency)
//   raddr_b/rdata_b   read port B (1-cycle latency)
//   clear_req         start a clear sequence (ignored while busy)
//   busy              clear sequence in progress
//   clear_done        one-cycle pulse on first idle cycle after a clear
//   wr_err            one-cycle pulse after a dropped write
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic              wr_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              wr_err_q, wr_err_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic waddr_ok;
  logic wr_acc;
  logic clr_en;
  logic clr_last;

  assign waddr_ok = (32'(waddr) < 32'(DEPTH));
  assign clr_en   = (state_q == ST_CLEAR);
  assign wr_acc   = write_en && !clr_en && waddr_ok;
  assign wr_err_d = write_en && !wr_acc;
  assign clr_last = (cnt_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        // clear_req is not looked at here: a running sequence never restarts.
        if (clr_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Writes only land in IDLE and clearing only happens in CLEAR, so the two
  // updates never target the array on the same edge. A write issued together
  // with clear_req lands first; the sequence starting next cycle zeroes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_acc) begin
        mem_q[waddr] <= wdata;
      end
      if (clr_en) begin
        mem_q[cnt_q] <= '0;
      end
    end
  end

  reg_file_rd_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_rd_a (
    .clk        (clk),
    .reset      (reset),
    .raddr_i    (raddr_a),
    .mem_i      (mem_q),
    .wr_en_i    (wr_acc),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .clr_en_i   (clr_en),
    .clr_addr_i (cnt_q),
    .rdata_o    (rdata_a)
  );

  reg_file_rd_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_rd_b (
    .clk        (clk),
    .reset      (reset),
    .raddr_i    (raddr_b),
    .mem_i      (mem_q),
    .wr_en_i    (wr_acc),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .clr_en_i   (clr_en),
    .clr_addr_i (cnt_q),
    .rdata_o    (rdata_b)
  );

  assign busy       = clr_en;
  assign clear_done = done_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        reset;

  // default geometry instance (64 x 4)
  logic        write_en;
  logic [1:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  raddr_a, raddr_b;
  logic [63:0] rdata_a, rdata_b;
  logic        clear_req, busy, clear_done, wr_err;

  // second instance (32 x 6)
  logic        w2_en;
  logic [2:0]  w2_addr;
  logic [31:0] w2_data;
  logic [2:0]  r2_a, r2_b;
  logic [31:0] rd2_a, rd2_b;
  logic        cr2, busy2, done2, err2;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_mem [4];
  int          clr_pos;
  int          nbusy, ndone;

  always #5 clk = ~clk;

  reg_file_mp u_dut (
    .clk        (clk),
    .reset      (reset),
    .write_en   (write_en),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr_a    (raddr_a),
    .rdata_a    (rdata_a),
    .raddr_b    (raddr_b),
    .rdata_b    (rdata_b),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .wr_err     (wr_err)
  );

  reg_file_mp #(.WIDTH(32), .DEPTH(6)) u_dut6 (
    .clk        (clk),
    .reset      (reset),
    .write_en   (w2_en),
    .waddr      (w2_addr),
    .wdata      (w2_data),
    .raddr_a    (r2_a),
    .rdata_a    (rd2_a),
    .raddr_b    (r2_b),
    .rdata_b    (rd2_b),
    .clear_req  (cr2),
    .busy       (busy2),
    .clear_done (done2),
    .wr_err     (err2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the 64x4 instance. The reference keeps the storage as an
  // array and applies the cycle's write and clear step to it; a read then
  // returns what the array holds after that edge.
  task automatic cyc(input logic we, input int wa, input logic [63:0] wd,
                     input int ra, input int rb, input logic cr);
    logic acc, exp_err, exp_done;
    write_en  = we;
    waddr     = wa[1:0];
    wdata     = wd;
    raddr_a   = ra[1:0];
    raddr_b   = rb[1:0];
    clear_req = cr;
    chk("busy", {63'd0, busy}, {63'd0, clr_pos >= 0});
    nbusy += int'(busy);
    acc      = we && (clr_pos < 0) && (wa < 4);
    exp_err  = we && !acc;
    exp_done = 1'b0;
    if (acc) m_mem[wa] = wd;
    if (clr_pos >= 0) begin
      m_mem[clr_pos] = '0;
      clr_pos++;
      if (clr_pos == 4) begin
        clr_pos  = -1;
        exp_done = 1'b1;
      end
    end else if (cr) begin
      clr_pos = 0;
    end
    @(posedge clk);
    #1;
    ndone += int'(clear_done);
    chk("rdata_a", rdata_a, m_mem[ra]);
    chk("rdata_b", rdata_b, m_mem[rb]);
    chk("wr_err", {63'd0, wr_err}, {63'd0, exp_err});
    chk("clear_done", {63'd0, clear_done}, {63'd0, exp_done});
  endtask

  task automatic cyc2(input logic we, input int wa, input logic [31:0] wd,
                      input int ra, input int rb, input logic cr);
    w2_en   = we;
    w2_addr = wa[2:0];
    w2_data = wd;
    r2_a    = ra[2:0];
    r2_b    = rb[2:0];
    cr2     = cr;
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    cyc(1'b1, 0, 64'd15, 0, 0, 1'b0);
    cyc(1'b1, 1, 64'd20, 0, 0, 1'b0);
    cyc(1'b1, 2, 64'd25, 0, 0, 1'b0);
    cyc(1'b1, 3, 64'd30, 0, 0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] fill_vals [4];
    int nb2, nd2;
    fill_vals[0] = 64'd15; fill_vals[1] = 64'd20;
    fill_vals[2] = 64'd25; fill_vals[3] = 64'd30;

    reset = 1'b0;
    write_en = 0; waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0; clear_req = 0;
    w2_en = 0; w2_addr = 0; w2_data = 0; r2_a = 0; r2_b = 0; cr2 = 0;
    for (int i = 0; i < 4; i++) m_mem[i] = '0;
    clr_pos = -1;
    nbusy = 0;
    ndone = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata_a", rdata_a, 64'd0);
    chk("rst_rdata_b", rdata_b, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, clear_done}, 64'd0);
    chk("rst_err", {63'd0, wr_err}, 64'd0);
    chk("rst6_rdata_a", {32'd0, rd2_a}, 64'd0);
    chk("rst6_busy", {63'd0, busy2}, 64'd0);
    reset = 1'b1;

    // fill straight after reset release, then read back on both ports
    fill();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 0, 64'd0, i, 3 - i, 1'b0);
      chk("fill_rd_a", rdata_a, fill_vals[i]);
      chk("fill_rd_b", rdata_b, fill_vals[3 - i]);
    end

    // write-first collision on both ports
    cyc(1'b1, 1, 64'd50, 1, 1, 1'b0);
    chk("coll_a", rdata_a, 64'd50);
    chk("coll_b", rdata_b, 64'd50);
    cyc(1'b1, 1, 64'd20, 0, 0, 1'b0);

    // plain clear: busy exactly 4 cycles, one done pulse, all zero after
    nbusy = 0; ndone = 0;
    cyc(1'b0, 0, 64'd0, 3, 2, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 0, 64'd0, i % 4, 3 - (i % 4), 1'b0);
    chk("clr_busy_len", 64'(nbusy), 64'd4);
    chk("clr_done_cnt", 64'(ndone), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 0, 64'd0, i, i, 1'b0);
      chk("clr_rd_zero", rdata_a, 64'd0);
    end

    // write and repeated clear_req during CLEAR are both ignored
    fill();
    nbusy = 0; ndone = 0;
    cyc(1'b0, 0, 64'd0, 2, 3, 1'b1);
    cyc(1'b0, 0, 64'd0, 2, 3, 1'b0);
    cyc(1'b1, 2, 64'd99, 2, 3, 1'b1);
    chk("busy_wr_err", {63'd0, wr_err}, 64'd1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 0, 64'd0, 2, 3, 1'b0);
    chk("busy_wr_rd2", rdata_a, 64'd0);
    chk("rereq_busy_len", 64'(nbusy), 64'd4);
    chk("rereq_done_cnt", 64'(ndone), 64'd1);

    // write and clear_req in the same idle cycle
    fill();
    cyc(1'b1, 3, 64'd77, 3, 0, 1'b1);
    chk("wr_clr_same", rdata_a, 64'd77);
    for (int i = 0; i < 5; i++) cyc(1'b0, 0, 64'd0, 3, i % 4, 1'b0);
    chk("wr_clr_after", rdata_a, 64'd0);

    // reset in the second busy cycle aborts the sequence
    fill();
    cyc(1'b0, 0, 64'd0, 3, 2, 1'b1);
    cyc(1'b0, 0, 64'd0, 3, 2, 1'b0);
    reset = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_rdata_a", rdata_a, 64'd0);
    chk("arst_rdata_b", rdata_b, 64'd0);
    chk("arst_done", {63'd0, clear_done}, 64'd0);
    for (int i = 0; i < 4; i++) m_mem[i] = '0;
    clr_pos = -1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) cyc(1'b0, 0, 64'd0, i % 4, 3 - (i % 4), 1'b0);
    chk("arst_no_done", 64'(ndone), 64'd0);

    // randomized traffic against the reference
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), {$urandom, $urandom},
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          ($urandom_range(0, 15) == 0));
    end

    // 32 x 6 instance: top entry, out-of-range write and read, 6-cycle clear
    cyc2(1'b1, 5, 32'd7, 5, 0, 1'b0);
    chk("d6_wr5_first", {32'd0, rd2_a}, 64'd7);
    chk("d6_wr5_err", {63'd0, err2}, 64'd0);
    cyc2(1'b0, 0, 32'd0, 5, 5, 1'b0);
    chk("d6_rd5_a", {32'd0, rd2_a}, 64'd7);
    chk("d6_rd5_b", {32'd0, rd2_b}, 64'd7);
    cyc2(1'b1, 7, 32'd123, 7, 5, 1'b0);
    chk("d6_oob_err", {63'd0, err2}, 64'd1);
    chk("d6_oob_rd", {32'd0, rd2_a}, 64'd0);
    chk("d6_keep5", {32'd0, rd2_b}, 64'd7);
    cyc2(1'b0, 0, 32'd0, 7, 6, 1'b0);
    chk("d6_err_pulse", {63'd0, err2}, 64'd0);
    chk("d6_rd7", {32'd0, rd2_a}, 64'd0);
    chk("d6_rd6", {32'd0, rd2_b}, 64'd0);
    cyc2(1'b0, 0, 32'd0, 5, 5, 1'b1);
    nb2 = 0; nd2 = 0;
    for (int i = 0; i < 8; i++) begin
      nb2 += int'(busy2);
      nd2 += int'(done2);
      cyc2(1'b0, 0, 32'd0, 5, 0, 1'b0);
    end
    chk("d6_busy_len", 64'(nb2), 64'd6);
    chk("d6_done_cnt", 64'(nd2), 64'd1);
    chk("d6_clr_rd5", {32'd0, rd2_a}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
